// File: rtl/sclk_mon_pkg.sv
// Shared types and helpers for the slow-clock monitor: FSM state encoding
// and the half-period tolerance window compare.
package sclk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } sclk_state_t;

  localparam int GOOD_CNT_W = 4;

  // Unsigned window test; a tolerance wider than the centre clamps the floor to 0.
  function automatic logic in_window(input logic [63:0] cnt,
                                     input logic [63:0] center,
                                     input logic [63:0] tol);
    logic [63:0] lo;
    lo = (tol > center) ? 64'd0 : center - tol;
    return (cnt >= lo) && (cnt <= center + tol);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for a slow asynchronous clock; o_edge pulses for
// one clk cycle on either polarity of the synchronized transition.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic r_sync_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_sync_p2 <= 1'b0;
    end else begin
      r_sync_p0 <= i_async;
      r_sync_p1 <= r_sync_p0;
      r_sync_p2 <= r_sync_p1;
    end
  end

  assign o_edge = r_sync_p1 ^ r_sync_p2;

endmodule

// File: rtl/sclk_monitor.sv
// Qualifies a divided slow clock: measures half-periods, locks after a run of
// in-tolerance edges, raises a sticky lost alarm. Optional min/max statistics
// are enabled by defining SCLK_MON_STATS_EN.
module sclk_monitor
  import sclk_mon_pkg::*;
#(
  parameter int HALF_PERIOD = 5000001,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             clr_lost,
  output logic             locked,
  output logic             lost,
  output logic             meas_valid,
  output logic [CNT_W-1:0] half_period
`ifdef SCLK_MON_STATS_EN
  ,
  output logic [CNT_W-1:0] min_half,
  output logic [CNT_W-1:0] max_half
`endif
);

  localparam logic [CNT_W-1:0]      LIMIT   = CNT_W'(HALF_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [GOOD_CNT_W-1:0] LOCK_N  = GOOD_CNT_W'(LOCK_COUNT);

  logic                  w_edge;
  logic                  w_good;
  logic                  w_timeout;
  logic                  w_clear;
  logic                  w_measure;
  logic [CNT_W-1:0]      r_cnt;
  logic [GOOD_CNT_W-1:0] r_good_cnt;
  sclk_state_t           r_state;

  sync_edge_detect u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (sclk_in),
    .o_edge  (w_edge)
  );

  assign w_good    = in_window(64'(r_cnt), 64'(HALF_PERIOD), 64'(TOL));
  assign w_timeout = !w_edge && (r_cnt == LIMIT);
  assign w_clear   = (r_state == LOST) && clr_lost;
  // The first edge out of IDLE only opens a window; a clear beats a same-cycle edge.
  assign w_measure = w_edge && (r_state != IDLE) && !w_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_period <= '0;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= w_measure;
      if (w_measure) half_period <= r_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_good_cnt <= '0;
      locked     <= 1'b0;
      lost       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state    <= ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (w_edge) begin
            if (w_good) begin
              if (r_good_cnt + 1'b1 == LOCK_N) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end
              r_good_cnt <= r_good_cnt + 1'b1;
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_good_cnt <= '0;
          end
        end
        LOCKED: begin
          if ((w_edge && !w_good) || w_timeout) begin
            r_state <= LOST;
            locked  <= 1'b0;
            lost    <= 1'b1;
          end
        end
        LOST: begin
          if (clr_lost) begin
            r_state    <= IDLE;
            r_good_cnt <= '0;
            lost       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          locked  <= 1'b0;
          lost    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCLK_MON_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_half <= '1;
      max_half <= '0;
    end else if (w_clear) begin
      min_half <= '1;
      max_half <= '0;
    end else if (w_measure) begin
      if (r_cnt < min_half) min_half <= r_cnt;
      if (r_cnt > max_half) max_half <= r_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sclk_monitor.sv
// Directed bench for sclk_monitor with HALF_PERIOD=10, TOL=1, LOCK_COUNT=4, CNT_W=8.
module tb_sclk_monitor;

  localparam int CNT_W = 8;

  typedef struct {
    int gap;  // clk cycles since the previous sclk_in edge
    bit mv;
    int hp;
    bit lk;
    bit ls;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sclk_in = 1'b0;
  logic             clr_lost = 1'b0;
  logic             locked;
  logic             lost;
  logic             meas_valid;
  logic [CNT_W-1:0] half_period;
`ifdef SCLK_MON_STATS_EN
  logic [CNT_W-1:0] min_half;
  logic [CNT_W-1:0] max_half;
`endif

  int checks = 0;
  int errors = 0;

  sclk_monitor #(
    .HALF_PERIOD (10),
    .TOL         (1),
    .LOCK_COUNT  (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk_in     (sclk_in),
    .clr_lost    (clr_lost),
    .locked      (locked),
    .lost        (lost),
    .meas_valid  (meas_valid),
    .half_period (half_period)
`ifdef SCLK_MON_STATS_EN
    ,
    .min_half    (min_half),
    .max_half    (max_half)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit mv, input int hp, input bit lk, input bit ls);
    chk({tag, " meas_valid"}, int'(meas_valid), int'(mv));
    chk({tag, " half_period"}, int'(half_period), hp);
    chk({tag, " locked"}, int'(locked), int'(lk));
    chk({tag, " lost"}, int'(lost), int'(ls));
  endtask

  // Edge lands gap cycles after the previous one; outputs show it 3 clocks after the toggle.
  task automatic apply(input string tag, input vec_t v);
    repeat (v.gap - 4) tick();
    sclk_in = ~sclk_in;
    repeat (3) tick();
    chk_outs(tag, v.mv, v.hp, v.lk, v.ls);
    tick();
    chk({tag, " pulse end"}, int'(meas_valid), 0);
  endtask

  vec_t tbl_lock[11] = '{
    '{10, 0, 0, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0},
    '{10, 1, 10, 1, 0}, '{9, 1, 9, 1, 0}, '{11, 1, 11, 1, 0}, '{9, 1, 9, 1, 0},
    '{11, 1, 11, 1, 0}, '{12, 1, 12, 0, 1}, '{10, 1, 10, 0, 1}
  };
  vec_t tbl_relock[5] = '{
    '{9, 0, 10, 0, 0}, '{11, 1, 11, 0, 0}, '{9, 1, 9, 0, 0}, '{11, 1, 11, 0, 0},
    '{9, 1, 9, 1, 0}
  };
  vec_t tbl_badacq[9] = '{
    '{10, 0, 9, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0},
    '{8, 1, 8, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0}, '{10, 1, 10, 0, 0},
    '{10, 1, 10, 1, 0}
  };
  vec_t tbl_stats[4] = '{
    '{10, 0, 0, 0, 0}, '{9, 1, 9, 0, 0}, '{11, 1, 11, 0, 0}, '{10, 1, 10, 0, 0}
  };

  initial begin
    int mv_seen;

    repeat (3) tick();
    chk_outs("reset", 1'b0, 0, 1'b0, 1'b0);
`ifdef SCLK_MON_STATS_EN
    chk("reset min_half", int'(min_half), 255);
    chk("reset max_half", int'(max_half), 0);
`endif
    reset = 1'b1;

    foreach (tbl_lock[i]) apply($sformatf("lock[%0d]", i), tbl_lock[i]);

    // Clear in the same cycle the edge is seen: clear wins, no measurement.
    repeat (6) tick();
    sclk_in = ~sclk_in;
    tick();
    tick();
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk_outs("clr+edge", 1'b0, 10, 1'b0, 1'b0);
    tick();

    foreach (tbl_relock[i]) apply($sformatf("relock[%0d]", i), tbl_relock[i]);

    // Stall while locked: lost exactly when the count reaches 12 with no edge.
    mv_seen = 0;
    repeat (10) begin
      tick();
      if (meas_valid) mv_seen++;
    end
    chk("stall pre lost", int'(lost), 0);
    chk("stall pre locked", int'(locked), 1);
    tick();
    if (meas_valid) mv_seen++;
    chk_outs("stall", 1'b0, 9, 1'b0, 1'b1);
    chk("stall mv pulses", mv_seen, 0);

    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk_outs("clr alone", 1'b0, 9, 1'b0, 1'b0);

    foreach (tbl_badacq[i]) apply($sformatf("badacq[%0d]", i), tbl_badacq[i]);

    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk_outs("clr in locked", 1'b0, 10, 1'b1, 1'b0);

    // Reset while an edge is being evaluated in LOCKED.
    repeat (4) tick();
    sclk_in = ~sclk_in;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_outs("async reset", 1'b0, 0, 1'b0, 1'b0);
    sclk_in = 1'b0;
    mv_seen = 0;
    repeat (3) begin
      tick();
      if (meas_valid) mv_seen++;
    end
    chk("reset mv pulses", mv_seen, 0);
    reset = 1'b1;

    foreach (tbl_stats[i]) apply($sformatf("stats[%0d]", i), tbl_stats[i]);
`ifdef SCLK_MON_STATS_EN
    chk("min_half", int'(min_half), 9);
    chk("max_half", int'(max_half), 11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sclk_monitor.md
Name: sclk_monitor

Overview:
- Receive-side partner of the team's clock divider. Watches a divided slow clock (sclk_in) in the fast clk domain.
- Measures each half-period in clk cycles and declares lock after a run of in-tolerance half-periods.
- Flags loss of the slow clock (stall or off-frequency) with a sticky alarm.
- Sits next to any consumer of sclk to qualify it before use.

Parameters:
- HALF_PERIOD, 5000001, expected clk cycles between consecutive sclk_in edges (divider terminal count + 1)
- TOL, 2, allowed +/- deviation in clk cycles
- LOCK_COUNT, 4, consecutive good half-periods required to lock (1..15)
- CNT_W, 32, counter/measurement width; must hold HALF_PERIOD+TOL+1

Ports:
- clk  in  1  fast system clock
- reset  in  1  asynchronous, active-low reset
- sclk_in  in  1  divided clock under observation, asynchronous to clk
- clr_lost  in  1  single-cycle request to clear the lost alarm
- locked  out  1  high while state==LOCKED
- lost  out  1  sticky alarm, high while state==LOST
- meas_valid  out  1  one-cycle pulse when half_period is updated
- half_period  out  CNT_W  last measured edge-to-edge distance in clk cycles

Behaviour:
- Reset (reset==0): sync flops=0, cnt=0, good_cnt=0, state=IDLE, locked=0, lost=0, meas_valid=0, half_period=0.
- Synchronizer: s1<=sclk_in, s2<=s1, s3<=s2. edge = s2^s3 (both polarities count).
- Latency: output update occurs on the 3rd clk rising edge after sclk_in's new value is first sampled.
- Counter:
  - On edge: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at all-ones.
  - Edges N clk cycles apart yield a measured cnt of N.
- good = (cnt >= HALF_PERIOD-TOL) && (cnt <= HALF_PERIOD+TOL). Unsigned compare; if TOL > HALF_PERIOD, the lower bound is 0.
- timeout = !edge && cnt == HALF_PERIOD+TOL+1.
- Measurement:
  - On edge in any state except IDLE: half_period<=cnt and meas_valid<=1 for one cycle.
  - The first edge after IDLE produces no measurement.
- FSM:
  - IDLE: edge -> ACQUIRE, good_cnt=0.
  - ACQUIRE:
    - good edge -> good_cnt+1; if good_cnt+1==LOCK_COUNT -> LOCKED.
    - bad edge -> good_cnt=0, stay.
    - timeout -> IDLE, good_cnt=0.
  - LOCKED: good edge stays. Bad edge or timeout -> LOST.
  - LOST:
    - Edges still update half_period and meas_valid.
    - clr_lost -> IDLE.
    - clr_lost and edge in the same cycle: clr_lost wins, no measurement.
- clr_lost outside LOST is ignored.
- Edge arriving when cnt==HALF_PERIOD+TOL+1 is a bad edge (same outcome as timeout).
- locked and lost are registered decodes of state; never both high.
- Reset mid-operation returns everything to reset values immediately, with no measurement pulse.

Optional Feature:
- Macro SCLK_MON_STATS_EN.
- Defined:
  - Adds outputs min_half [CNT_W] and max_half [CNT_W].
  - Updated on every meas_valid.
  - Reset values: min_half = all-ones, max_half = 0.
  - Also reset when leaving LOST via clr_lost.
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package sclk_mon_pkg: state enum (IDLE, ACQUIRE, LOCKED, LOST) as 2-bit typedef, plus the tolerance-window compare function.
- Sub-module sync_edge_detect: 3-flop synchronizer and edge output, reusable by other slow-clock consumers.

Test Plan:
Bench parameters: HALF_PERIOD=10, TOL=1, LOCK_COUNT=4, CNT_W=8.
- Reset low then high, sclk_in toggling every 10 clk -> first edge gives no meas_valid. Next 4 edges give half_period=10 with meas_valid. locked rises in the cycle after the 4th good measurement.
- Toggling alternately every 9 and 11 clk -> all good, reaches locked. Then one half-period of 12 -> lost=1, locked=0, half_period=12.
- Locked, then sclk_in held constant -> lost asserts when cnt reaches 12 without an edge, with no meas_valid pulse.
- In LOST, pulse clr_lost in the same cycle as an edge -> state IDLE, no meas_valid. Four subsequent good edges after the next edge -> locked again.
- In ACQUIRE with good_cnt=3, one 8-cycle half-period -> good_cnt cleared, locked stays 0. Lock then requires 4 further good edges.
- Assert reset mid-LOCKED -> all outputs 0 asynchronously. With SCLK_MON_STATS_EN, edges at 9,11,10 -> min_half=9, max_half=11.
